// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared encodings and constants for the iterative divider
package div_unit_pkg;

    localparam int DIV_DW    = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Stall polarity shared with the pipeline controller
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [DIV_DW-1:0] ZeroWord = '0;

endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division iteration on {rem, quo}
module div_unit_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic [DW-1:0] quo_i,
    input  logic [DW-1:0] dvsr_i,
    output logic [DW-1:0] rem_o,
    output logic [DW-1:0] quo_o
);

    logic [DW:0] shifted;
    logic [DW:0] trial;
    logic        ge;

    // Shift next dividend bit into the partial remainder and try the subtraction;
    // partial remainder stays below the divisor, so a non-negative trial fits DW bits
    always_comb begin
        shifted = {rem_i, quo_i[DW-1]};
        trial   = shifted - {1'b0, dvsr_i};
        ge      = ~trial[DW];
        rem_o   = ge ? trial[DW-1:0] : shifted[DW-1:0];
        quo_o   = {quo_i[DW-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider (signed/unsigned) with pipeline stall request
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DW    = DIV_DW,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          annul_i,
    input  logic          signed_div_i,
    input  logic [DW-1:0] opdata1_i,
    input  logic [DW-1:0] opdata2_i,
    output logic [2*DW-1:0] result_o,
    output logic          ready_o,
    output logic          stallreq_o
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [DW-1:0]     rem_nx, quo_nx;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [2*DW-1:0]   result_q, result_d;

    div_unit_step #(.DW(DW)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_nx),
        .quo_o  (quo_nx)
    );

    // FSM next state, operand latching, iteration and sign fix-up
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        unique case (state_q)
            DivFree: begin
                result_d = {ZeroWord, ZeroWord};
                if (start_i == DivStart && !annul_i) begin
                    state_d   = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                    cnt_d     = '0;
                    rem_d     = ZeroWord;
                    quo_d     = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
                    dvsr_d    = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
                    neg_quo_d = signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                    neg_rem_d = signed_div_i && opdata1_i[DW-1];
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = {ZeroWord, ZeroWord};
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == CNT_W'(DW)) begin
                    state_d  = DivEnd;
                    result_d = {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = {ZeroWord, ZeroWord};
                end
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
    assign stallreq_o = (start_i == DivStart && ready_o == DivResultNotReady && !annul_i) ? Stop : NoStop;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and scoreboard checks for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
    } vec_t;

    typedef struct {
        logic [63:0] r;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] r);
        exp_t e;
        int   n;
        int   st;
        logic zbad;
        logic hbad;
        @(posedge clk); #1;
        start_i = 1'b1; signed_div_i = s; opdata1_i = a; opdata2_i = b;
        sb.push_back('{r, (b == 0) ? 1 : 33});
        @(posedge clk); #1;
        opdata1_i = ~a; opdata2_i = b ^ 32'h5; signed_div_i = ~s;
        n = 0; st = 0; zbad = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            st += int'(stallreq_o);
            if (result_o != 64'd0) zbad = 1'b1;
        end
        e = sb.pop_front();
        chk("latency", 64'(n), 64'(e.lat));
        chk("stall_cycles", 64'(st), 64'(e.lat));
        chk("busy_result_zero", 64'(zbad), 64'd0);
        chk("result", result_o, e.r);
        hbad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (stallreq_o !== 1'b0 || ready_o !== 1'b1 || result_o !== e.r) hbad = 1'b1;
        end
        chk("hold_stable", 64'(hbad), 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("drop_ready", 64'(ready_o), 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        logic        abad;
        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000}};
        vecs[3] = '{1'b0, 32'd100,        32'd0,        64'd0};
        vecs[4] = '{1'b1, 32'hFFFFFFF9,   32'd0,        64'd0};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF}};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}};
        vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'd0}};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}};
        vecs[9] = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3}};

        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #12;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].r);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            if (rb == 0) begin
                rq = 0; rr = 0;
            end else if (rs) begin
                rq = $signed(ra) / $signed(rb);
                rr = $signed(ra) % $signed(rb);
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_div(rs, ra, rb, {rr, rq});
        end

        // Idle with start and annul together: annul wins
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        chk("idle_annul_stall", 64'(stallreq_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_annul_ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0; start_i = 1'b0;

        // Annul on step 10 of an in-flight divide
        @(posedge clk); #1;
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        abad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || stallreq_o !== 1'b0 || result_o !== 64'd0) abad = 1'b1;
        end
        chk("annul_no_ready", 64'(abad), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // Asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        start_i = 1'b0; rst = 1'b0;
        #1;
        chk("async_rst_ready", 64'(ready_o), 64'd0);
        chk("async_rst_result", result_o, 64'd0);
        chk("async_rst_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
